// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller: owns the PC, fetches one word at a time
// over a req/ack handshake, issues it to decode over valid/ready, and counts retirements.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h5c,
   parameter logic [31:0] HALT_PC  = 32'h94
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic [31:0] retired
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] r_inst;
   logic [31:0] w_inst_next;
   logic [31:0] r_inst_pc;
   logic [31:0] w_inst_pc_next;
   logic [31:0] r_retired;
   logic [31:0] w_retired_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_BOOT;
         r_pc      <= RESET_PC;
         r_inst    <= 32'h0;
         r_inst_pc <= 32'h0;
         r_retired <= 32'h0;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_inst    <= w_inst_next;
         r_inst_pc <= w_inst_pc_next;
         r_retired <= w_retired_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_inst_next    = r_inst;
      w_inst_pc_next = r_inst_pc;
      w_retired_next = r_retired;
      case (r_state)
         S_BOOT: begin
            w_state_next = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) begin
               w_inst_next    = imem_rdata;
               w_inst_pc_next = r_pc;
               w_state_next   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Redirect wins over halt, so a jump at HALT_PC keeps the core running.
            if (id_ready) begin
               w_retired_next = r_retired + 32'd1;
               if (redirect_valid) begin
                  w_pc_next    = {redirect_pc[31:2], 2'b00};
                  w_state_next = S_FETCH;
               end else if (r_inst_pc == HALT_PC) begin
                  w_state_next = S_HALT;
               end else begin
                  w_pc_next    = r_pc + 32'd4;
                  w_state_next = S_FETCH;
               end
            end
         end
         default: begin
            w_state_next = S_HALT;
         end
      endcase
   end

   assign imem_req   = (r_state == S_FETCH);
   assign imem_addr  = r_pc;
   assign inst_valid = (r_state == S_ISSUE);
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;
   assign halted     = (r_state == S_HALT);
   assign retired    = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: zero-wait stream, stalls, redirects, halt and reset.
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic [31:0] retired;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] TAG = 32'hC0DE_0000;

   fetch_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .retired        (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory word is a tagged copy of the address so each fetch is identifiable.
   assign imem_rdata = TAG ^ imem_addr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply reset for two edges and release; ends in FETCH at RESET_PC.
   task automatic do_reset();
      reset = 1'b1; imem_ack = 1'b0; id_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; imem_ack = 1'b0; id_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      tick(); tick();
      total++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: req=%b valid=%b halted=%b want 0 0 0", imem_req, inst_valid, halted);
      end
      total++;
      if (imem_addr !== 32'h5c || inst !== 32'h0 || inst_pc !== 32'h0 || retired !== 32'h0) begin
         bad++;
         $display("FAIL reset_regs: addr=%h inst=%h inst_pc=%h retired=%0d want 5c 0 0 0",
                  imem_addr, inst, inst_pc, retired);
      end
      reset = 1'b0;
      total++;
      if (imem_req !== 1'b0) begin
         bad++;
         $display("FAIL boot_req: got %b want 0", imem_req);
      end
      tick();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h5c) begin
         bad++;
         $display("FAIL first_fetch: req=%b addr=%h want 1 5c", imem_req, imem_addr);
      end
   endtask

   task automatic test_zero_wait();
      logic [31:0] pc;
      imem_ack = 1'b1; id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pc = 32'h5c + 32'(4 * i);
         total++;
         if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== pc) begin
            bad++;
            $display("FAIL zw_fetch[%0d]: req=%b valid=%b addr=%h want 1 0 %h", i, imem_req, inst_valid, imem_addr, pc);
         end
         tick();
         total++;
         if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_pc !== pc || inst !== (TAG ^ pc) || retired !== 32'(i)) begin
            bad++;
            $display("FAIL zw_issue[%0d]: valid=%b req=%b pc=%h inst=%h ret=%0d want 1 0 %h %h %0d",
                     i, inst_valid, imem_req, inst_pc, inst, retired, pc, TAG ^ pc, i);
         end
         tick();
      end
      total++;
      if (retired !== 32'd4 || imem_addr !== 32'h6c) begin
         bad++;
         $display("FAIL zw_end: ret=%0d addr=%h want 4 6c", retired, imem_addr);
      end
   endtask

   task automatic test_waits();
      do_reset();
      imem_ack = 1'b1; id_ready = 1'b1;
      tick(); tick();
      imem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) imem_ack = 1'b1;
         total++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h60) begin
            bad++;
            $display("FAIL wait_hold[%0d]: req=%b addr=%h want 1 60", i, imem_req, imem_addr);
         end
         tick();
      end
      total++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h60 || inst !== (TAG ^ 32'h60)) begin
         bad++;
         $display("FAIL wait_issue: valid=%b pc=%h inst=%h want 1 60 %h", inst_valid, inst_pc, inst, TAG ^ 32'h60);
      end
      tick(); tick();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) id_ready = 1'b1;
         total++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'h64 || inst !== (TAG ^ 32'h64) || retired !== 32'd2) begin
            bad++;
            $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h ret=%0d want 1 64 %h 2",
                     i, inst_valid, inst_pc, inst, retired, TAG ^ 32'h64);
         end
         tick();
      end
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h68 || retired !== 32'd3) begin
         bad++;
         $display("FAIL stall_next: req=%b addr=%h ret=%0d want 1 68 3", imem_req, imem_addr, retired);
      end
   endtask

   task automatic test_redirect();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h7e;
      tick();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h7c || retired !== 32'd4) begin
         bad++;
         $display("FAIL redir_target: req=%b addr=%h ret=%0d want 1 7c 4", imem_req, imem_addr, retired);
      end
      imem_ack = 1'b0; redirect_pc = 32'h200;
      tick();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h7c) begin
         bad++;
         $display("FAIL redir_in_fetch: req=%b addr=%h want 1 7c", imem_req, imem_addr);
      end
      imem_ack = 1'b1; redirect_valid = 1'b0;
      tick(); tick();
      total++;
      if (imem_addr !== 32'h80 || retired !== 32'd5) begin
         bad++;
         $display("FAIL redir_after: addr=%h ret=%0d want 80 5", imem_addr, retired);
      end
   endtask

   task automatic test_halt();
      for (int i = 0; i < 5; i++) begin
         tick(); tick();
      end
      tick();
      total++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h94 || halted !== 1'b0) begin
         bad++;
         $display("FAIL halt_pre: valid=%b pc=%h halted=%b want 1 94 0", inst_valid, inst_pc, halted);
      end
      tick();
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || retired !== 32'd11 || imem_addr !== 32'h94) begin
         bad++;
         $display("FAIL halt_enter: halted=%b req=%b valid=%b ret=%0d addr=%h want 1 0 0 11 94",
                  halted, imem_req, inst_valid, retired, imem_addr);
      end
      for (int i = 0; i < 20; i++) begin
         imem_ack = 1'($urandom_range(0, 1)); id_ready = 1'($urandom_range(0, 1));
         redirect_valid = 1'($urandom_range(0, 1)); redirect_pc = $urandom;
         tick();
         total++;
         if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h94 || retired !== 32'd11) begin
            bad++;
            $display("FAIL halt_frozen[%0d]: halted=%b req=%b addr=%h ret=%0d want 1 0 94 11",
                     i, halted, imem_req, imem_addr, retired);
         end
      end
   endtask

   task automatic test_halt_redirect();
      do_reset();
      imem_ack = 1'b1; id_ready = 1'b1;
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h94;
      tick();
      redirect_valid = 1'b0;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h94 || halted !== 1'b0) begin
         bad++;
         $display("FAIL redir_to_halt_pc: req=%b addr=%h halted=%b want 1 94 0", imem_req, imem_addr, halted);
      end
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h5c;
      tick();
      redirect_valid = 1'b0;
      total++;
      if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h5c || retired !== 32'd2) begin
         bad++;
         $display("FAIL halt_pc_redirect: halted=%b req=%b addr=%h ret=%0d want 0 1 5c 2",
                  halted, imem_req, imem_addr, retired);
      end
   endtask

   task automatic test_reset_cases();
      // Reset in FETCH with ack in the same cycle: request withdrawn, nothing captured.
      imem_ack = 1'b1; reset = 1'b1;
      tick();
      total++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || retired !== 32'd0 || inst_pc !== 32'h0 || imem_addr !== 32'h5c) begin
         bad++;
         $display("FAIL rst_fetch: req=%b valid=%b ret=%0d inst_pc=%h addr=%h want 0 0 0 0 5c",
                  imem_req, inst_valid, retired, inst_pc, imem_addr);
      end
      reset = 1'b0;
      tick();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h5c) begin
         bad++;
         $display("FAIL rst_fetch_next: req=%b addr=%h want 1 5c", imem_req, imem_addr);
      end
      tick();
      reset = 1'b1; id_ready = 1'b1;
      tick();
      total++;
      if (inst_valid !== 1'b0 || retired !== 32'd0) begin
         bad++;
         $display("FAIL rst_issue: valid=%b ret=%0d want 0 0", inst_valid, retired);
      end
      reset = 1'b0;
      tick();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h94;
      tick();
      redirect_valid = 1'b0;
      tick(); tick();
      total++;
      if (halted !== 1'b1 || retired !== 32'd2) begin
         bad++;
         $display("FAIL rst_halt_pre: halted=%b ret=%0d want 1 2", halted, retired);
      end
      reset = 1'b1;
      tick();
      total++;
      if (halted !== 1'b0 || retired !== 32'd0 || imem_addr !== 32'h5c) begin
         bad++;
         $display("FAIL rst_halt: halted=%b ret=%0d addr=%h want 0 0 5c", halted, retired, imem_addr);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      imem_ack = 1'b1; id_ready = 1'b0;
      tick();
      force dut.r_retired = 32'hffff_ffff;
      #1;
      release dut.r_retired;
      #1;
      id_ready = 1'b1;
      tick();
      total++;
      if (retired !== 32'h0 || imem_addr !== 32'h60 || imem_req !== 1'b1) begin
         bad++;
         $display("FAIL wrap: ret=%h addr=%h req=%b want 0 60 1", retired, imem_addr, imem_req);
      end
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; id_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      test_reset();
      test_zero_wait();
      test_waits();
      test_redirect();
      test_halt();
      test_halt_redirect();
      test_reset_cases();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
